// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
//   rx_state_t     : receiver FSM states
//   DATA_BITS      : payload bits per frame (8N1)
//   STOP_BIT_IDX   : position of the stop bit in the frame (start = 0, data = 1..8)
//   calc_div()     : clocks per oversample tick, rounded to nearest
//   decision_tick(): tick number at which frame bit n is decided
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS    = 8;
    localparam int STOP_BIT_IDX = DATA_BITS + 1;

    // round(clk_freq / (baud * oversample)) in integer arithmetic
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int rate;
        rate = baud * oversample;
        return (clk_freq + rate / 2) / rate;
    endfunction

    // Bit n is decided one tick past its centre, so the three-sample
    // majority window (ticks d-2..d) straddles the middle of the bit.
    function automatic int decision_tick(input int oversample, input int bit_idx);
        return oversample * bit_idx + oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   clk, reset : clock and asynchronous active-high reset
//   restart    : synchronous restart, the next tick arrives DIV clocks later
//   tick       : one-clock pulse every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_reg;

    assign tick = (cnt_reg == W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding a byte FIFO through a valid/ready push port.
//   clk, reset : clock and asynchronous active-high reset
//   rx         : raw serial line (idle high, asynchronous)
//   rx_data    : received byte, stable while rx_valid is high
//   rx_valid   : byte pending, held until rx_valid & rx_ready
//   rx_ready   : consumer accepts the pending byte
//   frame_err  : one-clock pulse when a stop bit is sampled low
//   overrun    : one-clock pulse when a byte is dropped because one is still pending
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CNT_W = $clog2(decision_tick(OVERSAMPLE, STOP_BIT_IDX) + 1);
    localparam int BIT_W = $clog2(STOP_BIT_IDX + 1);

    // input conditioning
    logic       sync1_reg;
    logic       rxs_reg;
    logic       rxs_prev_reg;
    logic [1:0] flush_reg;
    logic       armed_reg;
    logic       start_edge;

    // frame timing and data path
    rx_state_t             state_reg, state_next;
    logic [CNT_W-1:0]      os_cnt_reg;
    logic [CNT_W-1:0]      decision_cnt;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [1:0]            hist_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  tick;
    logic                  restart;
    logic                  at_decision;
    logic                  maj;
    logic                  shift_en;
    logic                  byte_done;
    logic                  frame_bad;
    logic                  end_frame;

    // output register
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       frame_err_reg;
    logic       overrun_reg;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // The synchroniser resets to 1, so for two clocks after reset rxs does
    // not reflect the line. flush_reg masks arming until the chain holds a
    // real sample; otherwise a line held low through reset would look like
    // a 1->0 edge right after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg    <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
            flush_reg    <= 2'b00;
            armed_reg    <= 1'b0;
        end else begin
            sync1_reg    <= rx;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;
            flush_reg    <= {flush_reg[0], 1'b1};
            if (end_frame) begin
                armed_reg <= 1'b0;
            end else if (rxs_reg && flush_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign start_edge = armed_reg & rxs_prev_reg & ~rxs_reg;

    // os_cnt counts ticks since the start edge; bit_cnt indexes the frame
    // bit being collected (0 = start, 1..8 = data, 9 = stop). A decision is
    // due on the tick that brings os_cnt up to decision_tick(bit_cnt).
    assign decision_cnt = CNT_W'(decision_tick(OVERSAMPLE, int'(bit_cnt_reg)) - 1);
    assign at_decision  = tick && (os_cnt_reg == decision_cnt);

    // hist_reg holds the samples from the two previous ticks
    assign maj = (hist_reg[1] & hist_reg[0]) |
                 (hist_reg[1] & rxs_reg) |
                 (hist_reg[0] & rxs_reg);

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        end_frame  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START: begin
                if (at_decision) begin
                    state_next = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_decision) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == BIT_W'(DATA_BITS)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (at_decision) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                    byte_done  = maj;
                    frame_bad  = ~maj;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            os_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            hist_reg    <= 2'b00;
            shift_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (restart) begin
                os_cnt_reg  <= '0;
                bit_cnt_reg <= '0;
            end else if (state_reg != IDLE && tick) begin
                os_cnt_reg <= os_cnt_reg + CNT_W'(1);
                if (at_decision) begin
                    bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                end
            end
            if (tick) begin
                hist_reg <= {hist_reg[0], rxs_reg};
            end
            // LSB arrives first, so shift right and insert at the top
            if (shift_en) begin
                shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // A completed byte loads if the slot is free or is being emptied in the
    // same cycle; otherwise the pending byte wins and the new one is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            overrun_reg   <= byte_done & rx_valid_reg & ~rx_ready;
            if (byte_done && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at a scaled-down rate: 1.6 MHz clock, 10 kbaud,
// 16x oversampling, giving DIV = 10 and 160 clocks per bit.
// The model predicts, per frame sent, whether the byte is delivered,
// dropped as an overrun or flagged as a framing error; a monitor checks
// every cycle against that prediction and the valid/ready rules.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int P        = CLK_FREQ / BAUD;   // 160 clocks per bit
    localparam int DIV_NOM  = 10;                // 1.6e6 / 160e3
    localparam int LAT_MIN  = 153 * DIV_NOM + 3; // 153*DIV + 4, +/-1
    localparam int LAT_MAX  = 153 * DIV_NOM + 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fails = 0;
    logic [7:0] exp_q[$];
    logic       model_pending = 1'b0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         byte_cnt = 0;
    int         last_byte_cyc = 0;
    int         t_fall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fails++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // every input change lands 2 time units after a rising edge
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] data, input int bclks, input logic stop);
        drive_bit(1'b0, bclks);
        for (int i = 0; i < 8; i++) drive_bit(data[i], bclks);
        drive_bit(stop, bclks);
    endtask

    // Frame-level outcome; rx_ready is held constant across each frame.
    task automatic model_frame(input logic [7:0] data, input logic stop_ok, input logic ready);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (model_pending && !ready) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(data);
            model_pending = !ready;
        end
    endtask

    task automatic frame(input logic [7:0] data, input int bclks, input logic stop);
        model_frame(data, stop, rx_ready);
        send_frame(data, bclks, stop);
    endtask

    task automatic checkpoint(input string name);
        check({name, "_bytes_outstanding"}, exp_q.size(), 0);
        check({name, "_frame_err_count"}, ferr_cnt, exp_ferr);
        check({name, "_overrun_count"}, ovr_cnt, exp_ovr);
    endtask

    task automatic monitor();
        logic       vp = 1'b0;
        logic       rp = 1'b0;
        logic       fp = 1'b0;
        logic       op = 1'b0;
        logic [7:0] dp = 8'h00;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (reset) begin
                vp = 1'b0; rp = 1'b0; fp = 1'b0; op = 1'b0; dp = rx_data;
            end else begin
                // a new byte is presented on a rise or right after a transfer
                if (rx_valid && (!vp || rp)) begin
                    byte_cnt++;
                    last_byte_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_byte: actual=%0h required=no byte", rx_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("rx_data", rx_data, exp_b);
                    end
                end
                if (vp && !rp) begin
                    check("valid_held", rx_valid, 1);
                    check("data_stable", rx_data, dp);
                end
                if (frame_err) begin
                    ferr_cnt++;
                    check("frame_err_width", fp, 0);
                end
                if (overrun) begin
                    ovr_cnt++;
                    check("overrun_width", op, 0);
                end
                vp = rx_valid; rp = rx_ready; fp = frame_err; op = overrun; dp = rx_data;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset with the line low; it must not start a frame afterwards
        wait_cyc(5);
        @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive_bit(1'b0, 2000);
        drive_bit(1'b1, 200);
        checkpoint("low_through_reset");

        // single frame, consumer ready
        rx_ready = 1'b1;
        t_fall = cyc;
        frame(8'h41, P, 1'b1);
        wait_cyc(P);
        check_range("valid_latency", last_byte_cyc - t_fall, LAT_MIN, LAT_MAX);
        check("first_byte_count", byte_cnt, 1);
        checkpoint("single_frame");

        // back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        frame(8'h41, P, 1'b1);
        frame(8'h42, P, 1'b1);
        wait_cyc(P);
        check("stalled_valid", rx_valid, 1);
        check("stalled_data", rx_data, 8'h41);
        check("stalled_overruns", ovr_cnt, 1);
        checkpoint("back_to_back");
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        model_pending = 1'b0;
        @(negedge clk);
        check("valid_after_accept", rx_valid, 0);
        @(posedge clk);
        #2;

        // short glitch, then a real frame
        rx_ready = 1'b1;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 300);
        frame(8'h55, P, 1'b1);
        wait_cyc(P);
        checkpoint("glitch");

        // framing error followed by a break
        frame(8'hA5, P, 1'b0);
        drive_bit(1'b0, 19 * P);
        drive_bit(1'b1, 3 * P);
        check("framing_err_count", ferr_cnt, 1);
        frame(8'h3C, P, 1'b1);
        wait_cyc(P);
        checkpoint("framing");

        // reset in the middle of bit 4 of 8'hFF
        drive_bit(1'b0, P);
        drive_bit(1'b1, 4 * P + P / 2);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("midframe_rx_data", rx_data, 8'h00);
        check("midframe_rx_valid", rx_valid, 0);
        check("midframe_frame_err", frame_err, 0);
        check("midframe_overrun", overrun, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_pending = 1'b0;
        drive_bit(1'b1, P / 2 + 4 * P + P);
        frame(8'h81, P, 1'b1);
        wait_cyc(P);
        checkpoint("midframe_reset");

        // rate skew of -2.5 % and +2.5 %
        frame(8'h5A, P - 4, 1'b1);
        wait_cyc(P);
        frame(8'h5A, P + 4, 1'b1);
        wait_cyc(P);
        checkpoint("skew");
        check("total_bytes", byte_cnt, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver that feeds the byte FIFO in `uart_fifo`: it deserialises the asynchronous `uart_rx` line (8N1, LSB first) into bytes. It presents each byte on a valid/ready push interface to the FIFO write side. It also flags framing errors and overruns; in the top level these drive status logic (LEDs).

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `BAUD`, 9600, line rate in bit/s
- `OVERSAMPLE`, 16, samples per bit; must be ≥ 8 and even
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock domain
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`
- `rx_data`  out  8  received byte, stable while `rx_valid`=1
- `rx_valid`  out  1  byte available; held until accepted
- `rx_ready`  in  1  consumer (FIFO not full) accepts; transfer when `rx_valid & rx_ready`
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `overrun`  out  1  one-cycle pulse, new byte completed while previous still pending

## Operation
- Input: 2-FF synchroniser, both flops reset to 1. Only the second-stage output (`rxs`) is used.
- Divider: DIV = round(CLK_FREQ / (BAUD·OVERSAMPLE)), which is 326 at the defaults. A tick is a one-clock pulse every DIV clocks.
  - The divider and tick counter `os_cnt` restart at 0 on start-edge detection.
- Arming flag: resets to 0 and sets when `rxs`=1. A start edge (`rxs` 1→0) is honoured only while armed. A line held low through reset or a break therefore never starts a frame.
- FSM states:
  - IDLE: wait for a start edge, then go to START.
  - START: at tick 9, majority of the samples at ticks 7, 8 and 9.
    - Majority 1: false start, return to IDLE, no output.
    - Majority 0: go to DATA.
  - DATA: bit k (0..7) is decided at tick 16·(k+1)+9, using the majority of ticks −2..0 around that point. It is shifted in LSB first. After bit 7, go to STOP.
  - STOP: decided at tick 153.
    - Majority 1: byte complete.
    - Majority 0: pulse `frame_err`, discard the byte.
    - Either way, return to IDLE and clear the arming flag.
- Tick offsets above assume OVERSAMPLE=16. In general the decision for bit n is at OVERSAMPLE·n + OVERSAMPLE/2 + 1.
- Output register on byte complete:
  - `rx_valid`=0, or `rx_valid & rx_ready` in the same cycle: load `rx_data`, `rx_valid`=1.
  - Otherwise: keep the old byte, pulse `overrun`, drop the new byte.
- `rx_valid` clears on the cycle after a transfer, unless a new byte loads in that same cycle.
- Reset at any time: FSM to IDLE, counters 0, shift register 0.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - Synchroniser = 1, arming flag = 0.
- Input latency: 2 clocks from `rx` to `rxs`, plus 1 clock for edge detection.
- `rx_valid` rises 153·DIV + 4 clocks (±1) after `rx` falls, which is 49,882 clocks at the defaults. That is mid stop bit, so a back-to-back frame is caught.
- Rate tolerance: the total must be within ±3 % of nominal. The rounding error at the defaults is +0.15 %.
- `rx_ready` is sampled only when `rx_valid`=1. There is no combinational path from `rx_ready` to any output.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP).
  - Function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE.
  - Localparams for data bits (8) and stop tick index.
- Sub-module `uart_baud_tick`: parameterised divider with synchronous restart input and a one-clock tick output. It is reused by the future transmitter.
- Target 150–250 lines of RTL total.

## Test plan
- Reset, then frame 8'h41 with 104,166 ns bits, `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=8'h41. No `frame_err` or `overrun`.
- Frames 8'h41 then 8'h42 back-to-back (no idle gap), `rx_ready`=0 until both are done → `rx_data` stays 8'h41, `overrun` pulses once. After `rx_ready`=1 for one cycle, `rx_valid`=0.
- 3 µs low glitch on idle line → no output, FSM back in IDLE. A following valid frame 8'h55 is received correctly.
- Frame 8'hA5 with stop bit driven low, then line held low 2 ms → `frame_err` pulses once, `rx_valid` stays 0, no new frame until `rx` returns high. The next frame 8'h3C is received.
- Assert `reset` mid-frame during bit 4 of 8'hFF → all outputs 0. No byte is produced from the truncated frame, and the next full frame 8'h81 is received.
- Baud skew: frames 8'h5A at bit periods ±2.5 % of nominal → correct data in both cases.
